// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one single-ported byte-addressed memory between the
// CPU memory stage and a word-burst DMA engine, interleaving them round-robin.
module dmem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    // CPU memory stage
    input  logic                  i_cpu_req,
    input  logic                  i_cpu_we,
    input  logic                  i_cpu_byte,
    input  logic [DATA_WIDTH-1:0] i_cpu_addr,
    input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
    output logic [DATA_WIDTH-1:0] o_cpu_rdata,
    output logic                  o_cpu_stall,
    // DMA engine
    input  logic                  i_dma_start,
    input  logic                  i_dma_dir,
    input  logic [DATA_WIDTH-1:0] i_dma_base,
    input  logic [LEN_WIDTH-1:0]  i_dma_len,
    input  logic [DATA_WIDTH-1:0] i_dma_wdata,
    output logic [DATA_WIDTH-1:0] o_dma_rdata,
    output logic                  o_dma_beat,
    output logic                  o_dma_busy,
    output logic                  o_dma_done,
    // Data memory pins
    output logic                  o_mem_we,
    output logic                  o_mem_st_byte,
    output logic                  o_mem_ld_byte,
    output logic [DATA_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wd,
    input  logic [DATA_WIDTH-1:0] i_mem_rd
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BURST,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [DATA_WIDTH-1:0] r_ptr;
    logic [LEN_WIDTH-1:0]  r_remaining;
    logic                  r_dir;
    logic                  r_last_grant;   // 0 = CPU, 1 = DMA

    logic                  w_in_burst;
    logic                  w_dma_beat;
    logic                  w_last_beat;

    assign w_in_burst  = (r_state == S_BURST);
    // The CPU wins only if it asked and the DMA had the previous grant.
    assign w_dma_beat  = w_in_burst & ~(i_cpu_req & r_last_grant);
    assign w_last_beat = w_dma_beat & (r_remaining == LEN_WIDTH'(1));

    assign o_dma_beat  = w_dma_beat;
    assign o_cpu_stall = i_cpu_req & w_dma_beat;
    assign o_dma_busy  = w_in_burst;
    assign o_dma_done  = (r_state == S_DONE);
    assign o_cpu_rdata = i_mem_rd;
    assign o_dma_rdata = i_mem_rd;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_dma_start) begin
                    w_state_next = (i_dma_len != '0) ? S_BURST : S_DONE;
                end
            end
            S_BURST: begin
                if (w_last_beat) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_mem_we      = i_cpu_req & i_cpu_we & ~i_rst;
        o_mem_st_byte = i_cpu_byte;
        o_mem_ld_byte = i_cpu_byte;
        o_mem_addr    = i_cpu_addr;
        o_mem_wd      = i_cpu_wdata;
        if (w_dma_beat) begin
            o_mem_we      = r_dir;
            o_mem_st_byte = 1'b0;
            o_mem_ld_byte = 1'b0;
            o_mem_addr    = r_ptr;
            o_mem_wd      = i_dma_wdata;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_remaining  <= '0;
            r_dir        <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_state <= w_state_next;
            if ((r_state == S_IDLE) && i_dma_start) begin
                r_ptr       <= i_dma_base;
                r_remaining <= i_dma_len;
                r_dir       <= i_dma_dir;
            end
            if (w_in_burst) begin
                r_last_grant <= w_dma_beat;
            end
            if (w_dma_beat) begin
                r_ptr       <= r_ptr + DATA_WIDTH'(4);
                r_remaining <= r_remaining - LEN_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a byte-addressed memory model on the mem pins,
// CPU accesses, DMA bursts, contention, zero length, abort and address wrap.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we, cpu_byte;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dma_start, dma_dir;
    logic [31:0] dma_base, dma_wdata, dma_rdata;
    logic [7:0]  dma_len;
    logic        dma_beat, dma_busy, dma_done;
    logic        mem_we, mem_st_byte, mem_ld_byte;
    logic [31:0] mem_addr, mem_wd, mem_rd;

    int n_cmp = 0;
    int n_err = 0;

    dmem_arbiter #(.DATA_WIDTH(32), .LEN_WIDTH(8)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_cpu_req    (cpu_req),
        .i_cpu_we     (cpu_we),
        .i_cpu_byte   (cpu_byte),
        .i_cpu_addr   (cpu_addr),
        .i_cpu_wdata  (cpu_wdata),
        .o_cpu_rdata  (cpu_rdata),
        .o_cpu_stall  (cpu_stall),
        .i_dma_start  (dma_start),
        .i_dma_dir    (dma_dir),
        .i_dma_base   (dma_base),
        .i_dma_len    (dma_len),
        .i_dma_wdata  (dma_wdata),
        .o_dma_rdata  (dma_rdata),
        .o_dma_beat   (dma_beat),
        .o_dma_busy   (dma_busy),
        .o_dma_done   (dma_done),
        .o_mem_we     (mem_we),
        .o_mem_st_byte(mem_st_byte),
        .o_mem_ld_byte(mem_ld_byte),
        .o_mem_addr   (mem_addr),
        .o_mem_wd     (mem_wd),
        .i_mem_rd     (mem_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: 1024 words indexed by addr[11:2], little-endian byte lanes.
    logic [31:0] mem [0:1023];
    logic [31:0] w_word;
    logic [7:0]  w_byte;

    assign w_word = mem[mem_addr[11:2]];
    always_comb begin
        case (mem_addr[1:0])
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
    end
    assign mem_rd = mem_ld_byte ? {24'h0, w_byte} : w_word;

    always @(posedge clk) begin
        if (mem_we) begin
            if (mem_st_byte) mem[mem_addr[11:2]][8*mem_addr[1:0] +: 8] <= mem_wd[7:0];
            else             mem[mem_addr[11:2]] <= mem_wd;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change just after a falling edge; outputs are sampled #1 later.
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cpu_load(input logic [31:0] addr, input logic byte_acc,
                            input logic [31:0] exp, input string tag);
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_byte = byte_acc;
        cpu_addr = addr;
        #1 check(tag, cpu_rdata, exp);
        tick();
        cpu_req  = 1'b0;
        cpu_byte = 1'b0;
    endtask

    task automatic dma_kick(input logic dir, input logic [31:0] base, input logic [7:0] len);
        dma_start = 1'b1;
        dma_dir   = dir;
        dma_base  = base;
        dma_len   = len;
        tick();
        dma_start = 1'b0;
    endtask

    initial begin
        logic exp_beat;
        logic [31:0] exp_addr;

        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        rst = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_byte = 1'b0;
        cpu_addr = 32'h0000_0040; cpu_wdata = 32'h1234_5678;
        dma_start = 1'b0; dma_dir = 1'b0; dma_base = 32'h0; dma_len = 8'd0; dma_wdata = 32'h0;

        // Reset held: no write, no stall, no DMA activity, address follows CPU
        #2;
        check("rst_mem_we", {31'b0, mem_we}, 32'd0);
        check("rst_stall", {31'b0, cpu_stall}, 32'd0);
        check("rst_busy_done_beat", {29'b0, dma_busy, dma_done, dma_beat}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0000_0040);
        @(negedge clk);
        rst = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0;

        // CPU word store, word load, byte load
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0001_0000; cpu_wdata = 32'hDEAD_BEEF;
        #1;
        check("sw_mem_we", {31'b0, mem_we}, 32'd1);
        check("sw_mem_addr", mem_addr, 32'h0001_0000);
        check("sw_stall", {31'b0, cpu_stall}, 32'd0);
        tick();
        cpu_load(32'h0001_0000, 1'b0, 32'hDEAD_BEEF, "lw_10000");
        cpu_load(32'h0001_0000, 1'b1, 32'h0000_00EF, "lbu_10000");

        // Uncontended DMA write burst, len 4 at 0x100
        dma_kick(1'b1, 32'h0000_0100, 8'd4);
        for (int k = 0; k < 4; k++) begin
            dma_wdata = 32'h1111_0000 + 32'(k);
            #1;
            check($sformatf("wr_beat%0d", k), {31'b0, dma_beat}, 32'd1);
            check($sformatf("wr_addr%0d", k), mem_addr, 32'h100 + 32'(4 * k));
            check($sformatf("wr_we%0d", k), {31'b0, mem_we}, 32'd1);
            check($sformatf("wr_busy_done%0d", k), {30'b0, dma_busy, dma_done}, 32'b10);
            tick();
        end
        #1;
        check("wr_done", {30'b0, dma_busy, dma_done}, 32'b01);
        check("wr_done_beat", {31'b0, dma_beat}, 32'd0);
        tick();
        check("wr_idle", {30'b0, dma_busy, dma_done}, 32'b00);
        cpu_load(32'h0000_0104, 1'b0, 32'h1111_0001, "lw_104");
        cpu_load(32'h0000_010C, 1'b0, 32'h1111_0003, "lw_10c");

        // Contention: DMA read len 3 at 0x100 against a held LW 0x200
        dma_kick(1'b0, 32'h0000_0100, 8'd3);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0200;
        for (int k = 0; k < 6; k++) begin
            exp_beat = (k % 2) == 1;
            exp_addr = exp_beat ? 32'h100 + 32'(4 * (k / 2)) : 32'h200;
            if (k == 1) begin
                dma_start = 1'b1; dma_dir = 1'b1; dma_base = 32'h300; dma_len = 8'd5;
            end else begin
                dma_start = 1'b0;
            end
            #1;
            check($sformatf("ct_beat%0d", k), {31'b0, dma_beat}, {31'b0, exp_beat});
            check($sformatf("ct_stall%0d", k), {31'b0, cpu_stall}, {31'b0, exp_beat});
            check($sformatf("ct_addr%0d", k), mem_addr, exp_addr);
            check($sformatf("ct_we%0d", k), {31'b0, mem_we}, 32'd0);
            if (exp_beat)
                check($sformatf("ct_rdata%0d", k), dma_rdata, 32'h1111_0000 + 32'(k / 2));
            tick();
        end
        dma_start = 1'b0;
        #1;
        check("ct_done", {31'b0, dma_done}, 32'd1);
        check("ct_done_stall", {31'b0, cpu_stall}, 32'd0);
        tick();
        cpu_req = 1'b0;
        check("ct_idle_busy", {31'b0, dma_busy}, 32'd0);

        // Zero-length start
        dma_kick(1'b1, 32'h0000_0140, 8'd0);
        #1;
        check("z_done", {31'b0, dma_done}, 32'd1);
        check("z_busy_beat", {30'b0, dma_busy, dma_beat}, 32'd0);
        tick();
        check("z_after", {29'b0, dma_busy, dma_done, dma_beat}, 32'd0);

        // Abort: len 8 write at 0x180, reset after two beats
        dma_kick(1'b1, 32'h0000_0180, 8'd8);
        for (int k = 0; k < 2; k++) begin
            dma_wdata = 32'h2222_0000 + 32'(k);
            #1 check($sformatf("ab_addr%0d", k), mem_addr, 32'h180 + 32'(4 * k));
            tick();
        end
        dma_wdata = 32'h2222_0002;
        rst = 1'b1;
        #1;
        check("ab_rst_outs", {28'b0, mem_we, dma_beat, dma_busy, dma_done}, 32'd0);
        tick();
        rst = 1'b0;
        #1 check("ab_no_done0", {30'b0, dma_busy, dma_done}, 32'd0);
        tick();
        check("ab_no_done1", {30'b0, dma_busy, dma_done}, 32'd0);
        cpu_load(32'h0000_0184, 1'b0, 32'h2222_0001, "ab_lw_184");
        cpu_load(32'h0000_0188, 1'b0, 32'h0000_0000, "ab_lw_188");

        dma_kick(1'b1, 32'h0000_0400, 8'd1);
        dma_wdata = 32'h3333_3333;
        #1;
        check("ab_new_beat", {31'b0, dma_beat}, 32'd1);
        check("ab_new_addr", mem_addr, 32'h0000_0400);
        tick();
        check("ab_new_done", {31'b0, dma_done}, 32'd1);
        tick();
        cpu_load(32'h0000_0400, 1'b0, 32'h3333_3333, "ab_lw_400");

        // Address wrap
        dma_kick(1'b0, 32'hFFFF_FFF8, 8'd3);
        for (int k = 0; k < 3; k++) begin
            exp_addr = 32'hFFFF_FFF8 + 32'(4 * k);
            #1 check($sformatf("wrap_addr%0d", k), mem_addr, exp_addr);
            tick();
        end
        check("wrap_done", {31'b0, dma_done}, 32'd1);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-ported byte-addressed data memory between the CPU memory stage and a word-burst DMA engine. Sits between those two requesters and the data memory's WE / StSrcM / LdSrcM / A / WD / RD pins. Owns a burst sequencer (base address, length counter, direction) and a round-robin arbiter that interleaves DMA beats with CPU accesses one per cycle. Stalls the CPU when it loses arbitration.

## Interface
- DATA_WIDTH, 32, data and address width
- LEN_WIDTH, 8, burst length field width in words; max burst is 2^LEN_WIDTH-1
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_req  in  1  CPU memory stage requests an access this cycle
- cpu_we  in  1  CPU access is a store
- cpu_byte  in  1  byte access (SB/LBU) when 1, word access (SW/LW) when 0
- cpu_addr  in  DATA_WIDTH  CPU byte address
- cpu_wdata  in  DATA_WIDTH  CPU store data
- cpu_rdata  out  DATA_WIDTH  equals mem_rd, combinational
- cpu_stall  out  1  cpu_req high and CPU not granted this cycle
- dma_start  in  1  start a burst; sampled only in IDLE
- dma_dir  in  1  1 = write memory, 0 = read memory; latched with dma_start
- dma_base  in  DATA_WIDTH  burst start byte address; latched with dma_start
- dma_len  in  LEN_WIDTH  burst length in words; latched with dma_start
- dma_wdata  in  DATA_WIDTH  write data, consumed in any cycle dma_beat=1
- dma_rdata  out  DATA_WIDTH  equals mem_rd; valid when dma_beat=1
- dma_beat  out  1  DMA owns the memory this cycle
- dma_busy  out  1  state is BURST
- dma_done  out  1  one-cycle pulse after the final beat
- mem_we, mem_st_byte, mem_ld_byte  out  1 each  to memory WE, StSrcM, LdSrcM
- mem_addr  out  DATA_WIDTH  to memory A
- mem_wd  out  DATA_WIDTH  to memory WD
- mem_rd  in  DATA_WIDTH  from memory RD; combinational read

## Operation
- States: IDLE, BURST, DONE.
  - IDLE → BURST on dma_start when latched length ≠ 0.
  - IDLE → DONE on dma_start when length = 0.
  - BURST → DONE on the edge ending the last beat.
  - DONE → IDLE unconditionally.
- Registers:
  - ptr: next beat address; loaded with dma_base at start.
  - remaining: beats left; loaded with dma_len at start.
  - dir: direction; loaded with dma_dir at start.
  - last_grant: 0 = CPU, 1 = DMA; reset value 1.
- IDLE and DONE: the CPU owns the memory.
  - mem_we = cpu_req & cpu_we; mem_st_byte = mem_ld_byte = cpu_byte; mem_addr = cpu_addr; mem_wd = cpu_wdata.
  - cpu_stall = 0, dma_beat = 0.
- BURST grant rule:
  - cpu_grant = cpu_req & last_grant.
  - dma_beat = ~cpu_grant.
  - With no CPU request, the DMA issues a beat every cycle.
  - Under sustained contention, grants strictly alternate.
  - last_grant updates each BURST cycle to whoever was granted.
- BURST CPU cycle: memory pins driven as in IDLE.
- BURST DMA beat:
  - mem_addr = ptr; mem_we = dir; mem_wd = dma_wdata; mem_st_byte = mem_ld_byte = 0 (word access).
  - At the edge: ptr += 4 (modulo 2^DATA_WIDTH, wraps silently) and remaining -= 1.
- mem_we is never 1 for a requester that is not granted. When cpu_req is low in a CPU-owned cycle, mem_we = 0.
- dma_start in BURST or DONE is ignored; latched fields are not disturbed.

## Timing
- A write commits at the rising edge ending the granted cycle.
- Read data is available combinationally in the granted cycle (zero-latency read).
- Burst start:
  - dma_start sampled at edge E; BURST (or DONE for length 0) from E.
  - First beat possible in the cycle after E.
- Uncontended burst of length L:
  - L consecutive beat cycles.
  - dma_done high for 1 cycle immediately after.
  - dma_busy high for exactly L cycles.
- Contention: each CPU grant in BURST delays the remaining beats by 1 cycle.
- Reset:
  - Takes effect immediately when rst rises, asynchronously: state = IDLE, remaining = 0, ptr = 0, dir = 0, last_grant = 1.
  - While rst is high: mem_we = 0; cpu_stall, dma_beat, dma_busy, dma_done all 0; mem_addr/mem_wd follow the CPU; cpu_rdata = dma_rdata = mem_rd.
  - Reset mid-burst aborts the burst with no dma_done pulse. Beats already written persist.

## Test plan
- Reset, then CPU store: cpu_req=1, cpu_we=1, cpu_byte=0, addr 0x10000, data 0xDEADBEEF → mem_we=1, mem_addr=0x10000, cpu_stall=0; a following LW of 0x10000 returns 0xDEADBEEF on cpu_rdata. With cpu_byte=1, a byte load returns 0x000000EF.
- DMA write: base 0x100, len 4, dir=1, cpu_req=0 → beats on 4 consecutive cycles at 0x100, 0x104, 0x108, 0x10C with mem_we=1; dma_done pulses in the 5th cycle; dma_busy then drops.
- Contention: DMA read, len 3, at 0x100, with cpu_req=1 held (LW 0x200) → grants run CPU, DMA, CPU, DMA, CPU, DMA; cpu_stall is high exactly on the 3 DMA cycles; dma_rdata matches the 0x100..0x108 contents; a dma_start issued mid-burst is ignored.
- Zero length: dma_start with len 0 → no dma_beat; dma_done high in the cycle after the start edge; dma_busy never asserts.
- Abort: len 8 write, rst pulsed after beat 2 → outputs clear immediately; only 2 words are written; no dma_done. A new start at base 0x400, len 1 then completes normally.
- Wrap: base 0xFFFFFFF8, len 3 → beat addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
